// File: rtl/la_capture_pkg.sv
// -----------------------------------------------------------------------------
// la_capture_pkg
// Shared definitions for the logic-analyzer capture controller:
//   - state_t           capture FSM states (encoding is visible on the bus)
//   - OFF_*             register offsets from BASE_ADDR
//   - MODE_*            TRIGGER_MODE values
// -----------------------------------------------------------------------------
package la_capture_pkg;

    typedef enum logic [2:0] {
        IDLE             = 3'd0,
        MOVE_TO_POSITION = 3'd1,
        IN_POSITION      = 3'd2,
        CAPTURING        = 3'd3,
        CAPTURED         = 3'd4
    } state_t;

    localparam logic [3:0] OFF_STATE      = 4'd0;
    localparam logic [3:0] OFF_MODE       = 4'd1;
    localparam logic [3:0] OFF_LOC        = 4'd2;
    localparam logic [3:0] OFF_COUNT      = 4'd3;
    localparam logic [3:0] OFF_START      = 4'd4;
    localparam logic [3:0] OFF_STOP       = 4'd5;
    localparam logic [3:0] OFF_READ_PTR   = 4'd6;
    localparam logic [3:0] OFF_WRITE_PTR  = 4'd7;
    localparam logic [3:0] OFF_DECIMATE   = 4'd8;

    localparam logic MODE_SINGLE    = 1'b0;
    localparam logic MODE_IMMEDIATE = 1'b1;

endpackage

// File: rtl/la_capture_regs.sv
// -----------------------------------------------------------------------------
// la_capture_regs
// Register-bus stage of the capture controller: registers every bus field
// through with one cycle of latency, substitutes read data on a window hit,
// holds the configuration registers and produces start/stop request pulses.
//
// Optional feature macro: LA_CAPTURE_DECIMATE_EN (implements offset 8).
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   addr_i/data_i/rw_i/valid_i bus input
//   addr_o/data_o/rw_o/valid_o registered bus output
//   i_state, i_rd_ptr, i_wr_ptr  read-only status from the FSM
//   o_mode, o_loc, o_count     configuration registers
//   o_decimate                 decimation register (feature builds only)
//   o_start, o_stop            single-cycle request pulses
// -----------------------------------------------------------------------------
module la_capture_regs #(
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           addr_i,
    input  logic [15:0]           data_i,
    input  logic                  rw_i,
    input  logic                  valid_i,
    output logic [15:0]           addr_o,
    output logic [15:0]           data_o,
    output logic                  rw_o,
    output logic                  valid_o,
    input  logic [2:0]            i_state,
    input  logic [ADDR_WIDTH-1:0] i_rd_ptr,
    input  logic [ADDR_WIDTH-1:0] i_wr_ptr,
    output logic                  o_mode,
    output logic [15:0]           o_loc,
    output logic [15:0]           o_count,
`ifdef LA_CAPTURE_DECIMATE_EN
    output logic [15:0]           o_decimate,
`endif
    output logic                  o_start,
    output logic                  o_stop
);
    import la_capture_pkg::*;

    localparam logic [15:0] BASE = 16'(BASE_ADDR);
`ifdef LA_CAPTURE_DECIMATE_EN
    localparam logic [15:0] LAST_OFF = 16'd8;
`else
    localparam logic [15:0] LAST_OFF = 16'd7;
`endif

    logic        r_mode;
    logic [15:0] r_loc;
    logic [15:0] r_count;
`ifdef LA_CAPTURE_DECIMATE_EN
    logic [15:0] r_decimate;
`endif

    logic [15:0] w_off;
    logic        w_in_win;
    logic        w_wr;
    logic        w_rd;
    logic        w_cfg_ok;
    logic [15:0] w_rdata;

    // The lower-bound test guards against the subtraction wrapping around.
    assign w_off    = addr_i - BASE;
    assign w_in_win = valid_i && (addr_i >= BASE) && (w_off <= LAST_OFF);
    assign w_wr     = w_in_win && rw_i;
    assign w_rd     = w_in_win && !rw_i;
    assign w_cfg_ok = (i_state == IDLE);

    assign o_start = w_wr && (w_off[3:0] == OFF_START);
    assign o_stop  = w_wr && (w_off[3:0] == OFF_STOP);

    always_comb begin
        w_rdata = 16'd0;
        case (w_off[3:0])
            OFF_STATE:     w_rdata = 16'(i_state);
            OFF_MODE:      w_rdata = {15'd0, r_mode};
            OFF_LOC:       w_rdata = r_loc;
            OFF_COUNT:     w_rdata = r_count;
            OFF_READ_PTR:  w_rdata = 16'(i_rd_ptr);
            OFF_WRITE_PTR: w_rdata = 16'(i_wr_ptr);
`ifdef LA_CAPTURE_DECIMATE_EN
            OFF_DECIMATE:  w_rdata = r_decimate;
`endif
            default:       w_rdata = 16'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_o     <= 16'd0;
            data_o     <= 16'd0;
            rw_o       <= 1'b0;
            valid_o    <= 1'b0;
            r_mode     <= MODE_SINGLE;
            r_loc      <= 16'd0;
            r_count    <= 16'd1;
`ifdef LA_CAPTURE_DECIMATE_EN
            r_decimate <= 16'd0;
`endif
        end else begin
            addr_o  <= addr_i;
            data_o  <= w_rd ? w_rdata : data_i;
            rw_o    <= rw_i;
            valid_o <= valid_i;
            // Configuration is frozen while a capture is in progress.
            if (w_wr && w_cfg_ok) begin
                case (w_off[3:0])
                    OFF_MODE:     r_mode     <= data_i[0];
                    OFF_LOC:      r_loc      <= data_i;
                    OFF_COUNT:    r_count    <= data_i;
`ifdef LA_CAPTURE_DECIMATE_EN
                    OFF_DECIMATE: r_decimate <= data_i;
`endif
                    default: ;
                endcase
            end
        end
    end

    assign o_mode     = r_mode;
    assign o_loc      = r_loc;
    assign o_count    = r_count;
`ifdef LA_CAPTURE_DECIMATE_EN
    assign o_decimate = r_decimate;
`endif

endmodule

// File: rtl/la_capture_controller.sv
// -----------------------------------------------------------------------------
// la_capture_controller
// Logic-analyzer capture controller: register window on the 16-bit bus
// daisy-chain plus the capture FSM driving a circular sample buffer.
//
// Optional feature macro: LA_CAPTURE_DECIMATE_EN (sample decimation).
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   addr_i/data_i/rw_i/valid_i bus input
//   addr_o/data_o/rw_o/valid_o registered bus output (1-cycle latency)
//   trig                       trigger match, sampled on sample strobes
//   bram_addr, bram_we         sample-memory write port
// -----------------------------------------------------------------------------
module la_capture_controller #(
    parameter int BASE_ADDR    = 0,
    parameter int SAMPLE_DEPTH = 4096,
    parameter int ADDR_WIDTH   = $clog2(SAMPLE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           addr_i,
    input  logic [15:0]           data_i,
    input  logic                  rw_i,
    input  logic                  valid_i,
    output logic [15:0]           addr_o,
    output logic [15:0]           data_o,
    output logic                  rw_o,
    output logic                  valid_o,
    input  logic                  trig,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_we
);
    import la_capture_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(SAMPLE_DEPTH - 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_wp;
    logic [ADDR_WIDTH-1:0] r_rp;
    logic [15:0]           r_trig_cnt;

    logic                  w_mode;
    logic [15:0]           w_loc;
    logic [15:0]           w_count;
    logic                  w_start;
    logic                  w_stop;
    logic                  w_start_ok;
    logic                  w_strobe;
    logic [ADDR_WIDTH-1:0] w_loc_eff;
    logic [15:0]           w_count_eff;
    logic [15:0]           w_trig_next;
    logic [ADDR_WIDTH-1:0] w_wp_inc;
    logic [ADDR_WIDTH-1:0] w_rp_inc;
`ifdef LA_CAPTURE_DECIMATE_EN
    logic [15:0]           w_decimate;
    logic [15:0]           r_dec_cnt;
`endif

    // Buffer depth need not be a power of two, so wrap explicitly.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    la_capture_regs #(
        .BASE_ADDR  (BASE_ADDR),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regs (
        .clk        (clk),
        .rst        (rst),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .rw_i       (rw_i),
        .valid_i    (valid_i),
        .addr_o     (addr_o),
        .data_o     (data_o),
        .rw_o       (rw_o),
        .valid_o    (valid_o),
        .i_state    (r_state),
        .i_rd_ptr   (r_rp),
        .i_wr_ptr   (r_wp),
        .o_mode     (w_mode),
        .o_loc      (w_loc),
        .o_count    (w_count),
`ifdef LA_CAPTURE_DECIMATE_EN
        .o_decimate (w_decimate),
`endif
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign w_loc_eff   = (32'(w_loc) > SAMPLE_DEPTH - 1) ? LAST_PTR : ADDR_WIDTH'(w_loc);
    assign w_count_eff = (w_count == 16'd0) ? 16'd1 : w_count;
    assign w_trig_next = r_trig_cnt + 16'd1;
    assign w_wp_inc    = ptr_inc(r_wp);
    assign w_rp_inc    = ptr_inc(r_rp);
    assign w_start_ok  = w_start && !w_stop && (r_state == IDLE);

`ifdef LA_CAPTURE_DECIMATE_EN
    // Strobe on count 0; the counter restarts at an accepted start so the
    // first sample of a capture is taken immediately.
    assign w_strobe = (r_dec_cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_dec_cnt <= 16'd0;
        end else if (r_dec_cnt >= w_decimate) begin
            r_dec_cnt <= 16'd0;
        end else begin
            r_dec_cnt <= r_dec_cnt + 16'd1;
        end
    end
`else
    assign w_strobe = 1'b1;
`endif

    assign bram_we   = w_strobe && ((r_state == MOVE_TO_POSITION) ||
                                    (r_state == IN_POSITION) ||
                                    (r_state == CAPTURING));
    assign bram_addr = r_wp;

    always_ff @(posedge clk) begin
        if (rst || w_stop) begin
            r_state    <= IDLE;
            r_wp       <= '0;
            r_rp       <= '0;
            r_trig_cnt <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_wp       <= '0;
                        r_rp       <= '0;
                        r_trig_cnt <= 16'd0;
                        if (w_mode == MODE_IMMEDIATE)
                            r_state <= CAPTURING;
                        else if (w_loc_eff == '0)
                            r_state <= IN_POSITION;
                        else
                            r_state <= MOVE_TO_POSITION;
                    end
                end
                MOVE_TO_POSITION: begin
                    if (w_strobe) begin
                        r_wp <= w_wp_inc;
                        if (w_wp_inc == w_loc_eff)
                            r_state <= IN_POSITION;
                    end
                end
                IN_POSITION: begin
                    if (w_strobe) begin
                        r_wp <= w_wp_inc;
                        if (trig && (w_trig_next == w_count_eff)) begin
                            // read_pointer holds here so the trigger sample
                            // lands exactly loc entries after the oldest one.
                            // With loc = depth-1 the buffer is already full.
                            r_trig_cnt <= w_trig_next;
                            r_state    <= (w_wp_inc == r_rp) ? CAPTURED : CAPTURING;
                        end else begin
                            r_rp <= w_rp_inc;
                            if (trig)
                                r_trig_cnt <= w_trig_next;
                        end
                    end
                end
                CAPTURING: begin
                    if (w_strobe) begin
                        r_wp <= w_wp_inc;
                        if (w_wp_inc == r_rp)
                            r_state <= CAPTURED;
                    end
                end
                CAPTURED: ;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_la_capture_controller.sv
// -----------------------------------------------------------------------------
// tb_la_capture_controller
// Directed bench for la_capture_controller with SAMPLE_DEPTH=8, BASE_ADDR=0x10.
// Honours LA_CAPTURE_DECIMATE_EN when the build defines it.
// -----------------------------------------------------------------------------
module tb_la_capture_controller;

    localparam logic [15:0] BASE = 16'h0010;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr_i;
    logic [15:0] data_i;
    logic        rw_i;
    logic        valid_i;
    logic [15:0] addr_o;
    logic [15:0] data_o;
    logic        rw_o;
    logic        valid_o;
    logic        trig;
    logic [2:0]  bram_addr;
    logic        bram_we;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    la_capture_controller #(
        .BASE_ADDR    (16),
        .SAMPLE_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .rw_i      (rw_i),
        .valid_i   (valid_i),
        .addr_o    (addr_o),
        .data_o    (data_o),
        .rw_o      (rw_o),
        .valid_o   (valid_o),
        .trig      (trig),
        .bram_addr (bram_addr),
        .bram_we   (bram_we)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One bus transaction; returns the registered data_o one cycle later.
    task automatic bus(input logic [15:0] a, input logic [15:0] d, input logic w,
                       output logic [15:0] rdata);
        @(negedge clk);
        addr_i  = a;
        data_i  = d;
        rw_i    = w;
        valid_i = 1'b1;
        @(negedge clk);
        rdata   = data_o;
        valid_i = 1'b0;
        rw_i    = 1'b0;
    endtask

    task automatic reg_wr(input logic [15:0] off, input logic [15:0] d);
        logic [15:0] unused_rd;
        bus(BASE + off, d, 1'b1, unused_rd);
    endtask

    task automatic expect_reg(input string tag, input logic [15:0] off, input logic [15:0] exp);
        logic [15:0] v;
        bus(BASE + off, 16'hA5A5, 1'b0, v);
        check_eq(tag, 32'(v), 32'(exp));
    endtask

    // Called on the negedge right after the start write returns. Expects
    // bram_we high for cycles 0..last_we with address i mod 8, low afterwards.
    task automatic run_capture(input string tag, input int ncyc, input int last_we,
                               input logic [31:0] trig_mask);
        for (int i = 0; i < ncyc; i++) begin
            if (i > 0) @(negedge clk);
            check_eq({tag, "_we"}, 32'(bram_we), (i <= last_we) ? 32'd1 : 32'd0);
            if (i <= last_we)
                check_eq({tag, "_addr"}, 32'(bram_addr), 32'(i % 8));
            trig = trig_mask[i];
        end
        trig = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        rst = 1'b1; addr_i = 16'd0; data_i = 16'd0; rw_i = 1'b0; valid_i = 1'b0; trig = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_addr_o",  32'(addr_o), 32'd0);
        check_eq("rst_data_o",  32'(data_o), 32'd0);
        check_eq("rst_valid_o", 32'(valid_o), 32'd0);
        check_eq("rst_rw_o",    32'(rw_o), 32'd0);
        check_eq("rst_we",      32'(bram_we), 32'd0);
        check_eq("rst_baddr",   32'(bram_addr), 32'd0);
        rst = 1'b0;

        // Reset values of the register window.
        expect_reg("rst_state", 16'd0, 16'd0);
        expect_reg("rst_mode",  16'd1, 16'd0);
        expect_reg("rst_loc",   16'd2, 16'd0);
        expect_reg("rst_count", 16'd3, 16'd1);
        expect_reg("rd_start",  16'd4, 16'd0);
        expect_reg("rst_rp",    16'd6, 16'd0);
        expect_reg("rst_wp",    16'd7, 16'd0);
`ifdef LA_CAPTURE_DECIMATE_EN
        expect_reg("rst_decim", 16'd8, 16'd0);
`else
        expect_reg("off8_pass", 16'd8, 16'hA5A5);
`endif

        // Out-of-window traffic passes unchanged.
        bus(BASE - 16'd1, 16'h1234, 1'b0, v);
        check_eq("oow_lo_data", 32'(v), 32'h1234);
        check_eq("oow_lo_addr", 32'(addr_o), 32'(BASE - 16'd1));
        bus(BASE + 16'd9, 16'h5678, 1'b0, v);
        check_eq("oow_hi_data", 32'(v), 32'h5678);
        // In-window writes still pass downstream.
        bus(BASE + 16'd2, 16'h0003, 1'b1, v);
        check_eq("wr_pass_data", 32'(v), 32'h0003);
        check_eq("wr_pass_rw",   32'(rw_o), 32'd1);
        check_eq("wr_pass_vld",  32'(valid_o), 32'd1);

        // Single-shot, loc=3, count=1. Writes 0,1,2 pre-fill, then IN_POSITION
        // from address 3; trig in cycle 8 (6th IN_POSITION cycle) hits addr 0,
        // read_pointer holds at 5, capture writes 1..4, done at wp=5.
        // trig in cycle 1 falls in MOVE_TO_POSITION and must be ignored.
        reg_wr(16'd3, 16'd1);
        reg_wr(16'd1, 16'd0);
        reg_wr(16'd4, 16'd0);
        run_capture("ss", 14, 12, 32'h0000_0102);
        expect_reg("ss_state", 16'd0, 16'd4);
        expect_reg("ss_rp",    16'd6, 16'd5);
        expect_reg("ss_wp",    16'd7, 16'd5);
        // trigger sample address 0 == (READ_POINTER + 3) mod 8
        reg_wr(16'd4, 16'd0);
        expect_reg("start_ignored", 16'd0, 16'd4);
        reg_wr(16'd5, 16'd0);
        expect_reg("stop_state", 16'd0, 16'd0);

        // loc=20 clamps to 7: writes 0..6 in MOVE, addr 7 is the first
        // IN_POSITION sample; trig there leaves the buffer full at once.
        reg_wr(16'd2, 16'd20);
        expect_reg("loc_raw", 16'd2, 16'd20);
        reg_wr(16'd4, 16'd0);
        run_capture("clamp", 10, 7, 32'h0000_0088);
        expect_reg("clamp_state", 16'd0, 16'd4);
        expect_reg("clamp_rp",    16'd6, 16'd0);
        reg_wr(16'd5, 16'd0);

        // count=3, loc=0: pulses in cycles 1,3,5; only the 3rd triggers.
        reg_wr(16'd2, 16'd0);
        reg_wr(16'd3, 16'd3);
        reg_wr(16'd4, 16'd0);
        run_capture("cnt3", 15, 12, 32'h0000_002A);
        expect_reg("cnt3_state", 16'd0, 16'd4);
        expect_reg("cnt3_rp",    16'd6, 16'd5);
        expect_reg("cnt3_wp",    16'd7, 16'd5);
        reg_wr(16'd5, 16'd0);

        // count=0 behaves as 1: trig in cycle 2 triggers.
        reg_wr(16'd3, 16'd0);
        expect_reg("cnt0_raw", 16'd3, 16'd0);
        reg_wr(16'd4, 16'd0);
        run_capture("cnt0", 12, 9, 32'h0000_0004);
        expect_reg("cnt0_rp", 16'd6, 16'd2);
        reg_wr(16'd5, 16'd0);

        // Immediate mode: exactly 8 writes at addresses 0..7.
        reg_wr(16'd1, 16'd1);
        reg_wr(16'd4, 16'd0);
        run_capture("imm", 10, 7, 32'h0);
        expect_reg("imm_state", 16'd0, 16'd4);
        expect_reg("imm_wp",    16'd7, 16'd0);
        reg_wr(16'd5, 16'd0);

        // Config write during CAPTURING is ignored; stop returns to IDLE.
        reg_wr(16'd4, 16'd0);
        reg_wr(16'd2, 16'd5);
        reg_wr(16'd5, 16'd0);
        check_eq("stop_we",    32'(bram_we), 32'd0);
        check_eq("stop_baddr", 32'(bram_addr), 32'd0);
        expect_reg("stop_st", 16'd0, 16'd0);
        expect_reg("stop_rp", 16'd6, 16'd0);
        expect_reg("stop_wp", 16'd7, 16'd0);
        expect_reg("cfg_lock", 16'd2, 16'd0);

        // Reset mid-capture.
        reg_wr(16'd4, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstm_we",    32'(bram_we), 32'd0);
        check_eq("rstm_baddr", 32'(bram_addr), 32'd0);
        rst = 1'b0;
        expect_reg("rstm_state", 16'd0, 16'd0);
        expect_reg("rstm_mode",  16'd1, 16'd0);
        expect_reg("rstm_count", 16'd3, 16'd1);

`ifdef LA_CAPTURE_DECIMATE_EN
        // DECIMATE=2, immediate: a write every 3rd cycle, 8 in total.
        reg_wr(16'd1, 16'd1);
        reg_wr(16'd8, 16'd2);
        expect_reg("decim_rd", 16'd8, 16'd2);
        reg_wr(16'd4, 16'd0);
        for (int i = 0; i < 26; i++) begin
            if (i > 0) @(negedge clk);
            check_eq("dec_we", 32'(bram_we), ((i % 3 == 0) && (i <= 21)) ? 32'd1 : 32'd0);
            if ((i % 3 == 0) && (i <= 21))
                check_eq("dec_addr", 32'(bram_addr), 32'(i / 3));
        end
        expect_reg("dec_state", 16'd0, 16'd4);
        reg_wr(16'd5, 16'd0);
`else
        // Without the feature offset 8 writes pass through and change nothing.
        bus(BASE + 16'd8, 16'h0002, 1'b1, v);
        check_eq("off8_wr_pass", 32'(v), 32'h0002);
        expect_reg("off8_rd_pass", 16'd8, 16'hA5A5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
